// File: rtl/fetch_if.sv
// fetch_if: fetch-unit bus bundling both memory read ports, redirect, and decode output/consume signals.
interface fetch_if;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic [31:0] instr_addr1;
  logic [31:0] instr_rdata1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out0_valid;
  logic [31:0] out0_instr;
  logic [31:0] out0_pc;
  logic        out1_valid;
  logic [31:0] out1_instr;
  logic [31:0] out1_pc;
  logic [1:0]  deq_num;
  modport master (
    output instr_addr, instr_addr1, out0_valid, out0_instr, out0_pc, out1_valid, out1_instr, out1_pc,
    input  instr_rdata, instr_rdata1, redirect_valid, redirect_pc, deq_num
  );
  modport slave (
    input  instr_addr, instr_addr1, out0_valid, out0_instr, out0_pc, out1_valid, out1_instr, out1_pc,
    output instr_rdata, instr_rdata1, redirect_valid, redirect_pc, deq_num
  );
endinterface

// File: rtl/dual_fetch_queue.sv
// dual_fetch_queue: two-wide instruction fetch into a circular queue, dual-issue output, redirect flush.
// Optional FETCH_STATS_EN adds stat_fetched / stat_flushes counters.
module dual_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushes
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  logic [31:0]   r_pc;
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pcs   [DEPTH];
  logic [31:0]   w_pc1;
  logic [AW:0]   w_free;
  logic [1:0]    w_enq, w_req, w_deq;
  logic [AW-1:0] w_t1, w_h1;
  assign w_pc1  = r_pc + 32'd4;
  assign w_t1   = r_tail + AW'(1);
  assign w_h1   = r_head + AW'(1);
  // enqueue depends only on registered count, keeping deq_num off the address path
  assign w_free = L_DEPTH - r_count;
  assign w_enq  = (w_free >= (AW+1)'(2)) ? 2'd2 : (w_free == (AW+1)'(1)) ? 2'd1 : 2'd0;
  assign w_req  = (bus.deq_num == 2'd3) ? 2'd2 : bus.deq_num;
  assign w_deq  = ((AW+1)'(w_req) > r_count) ? r_count[1:0] : w_req;
  assign bus.instr_addr  = r_pc;
  assign bus.instr_addr1 = w_pc1;
  assign bus.out0_valid  = r_count != '0;
  assign bus.out1_valid  = r_count >= (AW+1)'(2);
  assign bus.out0_instr  = bus.out0_valid ? r_instr[r_head] : '0;
  assign bus.out0_pc     = bus.out0_valid ? r_pcs[r_head]   : '0;
  assign bus.out1_instr  = bus.out1_valid ? r_instr[w_h1]   : '0;
  assign bus.out1_pc     = bus.out1_valid ? r_pcs[w_h1]     : '0;
  always_ff @(posedge clk) begin
    if (!bus.redirect_valid && w_enq != 2'd0) begin
      r_instr[r_tail] <= bus.instr_rdata;
      r_pcs[r_tail]   <= r_pc;
    end
    if (!bus.redirect_valid && w_enq == 2'd2) begin
      r_instr[w_t1] <= bus.instr_rdata1;
      r_pcs[w_t1]   <= w_pc1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.redirect_valid) begin
      r_pc    <= {bus.redirect_pc[31:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_pc    <= r_pc + {28'd0, w_enq, 2'b00};
      r_tail  <= r_tail + AW'(w_enq);
      r_head  <= r_head + AW'(w_deq);
      r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_deq);
    end
  end
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_flushes <= '0;
    end else if (bus.redirect_valid) begin
      stat_flushes <= stat_flushes + 32'd1;
    end else begin
      stat_fetched <= stat_fetched + {30'd0, w_enq};
    end
  end
`endif
endmodule

// File: tb/tb_dual_fetch_queue.sv
// tb_dual_fetch_queue: scoreboard bench; a queue-based fetch model predicts every cycle's outputs.
module tb_dual_fetch_queue;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int DEPTH = 4;
  localparam int N = 450;
  typedef struct {
    logic        v0, v1;
    logic [31:0] i0, p0, i1, p1, a0, a1, sf, sl;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_if bus();
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushes;
`endif
  exp_t sb[$];
  logic [31:0] mq[$];
  logic [31:0] mpc;
  logic [31:0] m_fetched, m_flushes;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction
  assign bus.instr_rdata  = mem(bus.instr_addr);
  assign bus.instr_rdata1 = mem(bus.instr_addr1);
  dual_fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushes(stat_flushes)
`endif
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  task automatic m_reset();
    mq.delete();
    mpc = RPC;
    m_fetched = 0;
    m_flushes = 0;
  endtask
  task automatic m_step(input logic rdir, input logic [31:0] rpc, input int dq);
    int enq, d, room;
    if (rdir) begin
      mq.delete();
      mpc = rpc & ~32'd3;
      m_flushes++;
      return;
    end
    room = DEPTH - mq.size();
    enq = room >= 2 ? 2 : room;
    d = dq > 2 ? 2 : dq;
    if (d > mq.size()) d = mq.size();
    repeat (d) void'(mq.pop_front());
    repeat (enq) begin
      mq.push_back(mpc);
      mpc += 4;
    end
    m_fetched += enq;
  endtask
  function automatic exp_t predict(input logic in_rst);
    exp_t e;
    e = '{default: '0};
    e.a0 = in_rst ? RPC : mpc;
    e.a1 = e.a0 + 32'd4;
    if (!in_rst) begin
      e.sf = m_fetched;
      e.sl = m_flushes;
      if (mq.size() >= 1) begin e.v0 = 1; e.p0 = mq[0]; e.i0 = mem(mq[0]); end
      if (mq.size() >= 2) begin e.v1 = 1; e.p1 = mq[1]; e.i1 = mem(mq[1]); end
    end
    return e;
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("instr_addr", bus.instr_addr, e.a0);
        chk("instr_addr1", bus.instr_addr1, e.a1);
        chk("out0_valid", 32'(bus.out0_valid), 32'(e.v0));
        chk("out0_pc", bus.out0_pc, e.p0);
        chk("out0_instr", bus.out0_instr, e.i0);
        chk("out1_valid", 32'(bus.out1_valid), 32'(e.v1));
        chk("out1_pc", bus.out1_pc, e.p1);
        chk("out1_instr", bus.out1_instr, e.i1);
`ifdef FETCH_STATS_EN
        chk("stat_fetched", stat_fetched, e.sf);
        chk("stat_flushes", stat_flushes, e.sl);
`endif
      end
    end
  end
  initial begin
    logic do_rst, rdir;
    logic [31:0] rpc;
    int dq;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.deq_num = '0;
    m_reset();
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      do_rst = (c == 0) || (c >= 40 && $urandom_range(0, 49) == 0);
      rdir = 1'b0;
      rpc = '0;
      dq = 0;
      if (c < 10) dq = 0;
      else if (c < 18) dq = 2;
      else if (c < 22) dq = 0;
      else if (c == 22) begin rdir = 1'b1; rpc = 32'h0000_2002; dq = 2; end
      else if (c < 31) dq = 2;
      else begin
        rdir = $urandom_range(0, 19) == 0;
        rpc = $urandom;
        dq = $urandom_range(0, 3);
      end
      if (do_rst) rdir = 1'b0;
      rst = do_rst;
      bus.redirect_valid = rdir;
      bus.redirect_pc = rpc;
      bus.deq_num = 2'(dq);
      sb.push_back(predict(do_rst));
      if (do_rst) m_reset();
      else m_step(rdir, rpc, dq);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
